// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package lsu_pkg;

  // funct3 memory width codes, shared with instruction decoding
  typedef enum logic [2:0] {
    BYTE   = 3'b000,
    HALF   = 3'b001,
    WORD   = 3'b010,
    BYTE_U = 3'b100,
    HALF_U = 3'b101
  } MemWidth;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } LsuState;

  // Number of bytes moved for a width code; illegal codes report 1
  function automatic logic [2:0] width_bytes(input MemWidth w);
    case (w)
      HALF, HALF_U: return 3'd2;
      WORD:         return 3'd4;
      default:      return 3'd1;
    endcase
  endfunction

  // Unsigned widths only make sense for loads; reserved codes are never legal
  function automatic logic width_legal(input MemWidth w, input logic write);
    case (w)
      BYTE, HALF, WORD: return 1'b1;
      BYTE_U, HALF_U:   return !write;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Turns the little-endian load accumulator into the sign/zero-extended result.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] acc,
  input  MemWidth     width,
  output logic [31:0] data
);

  // Pick the live bytes for the width and extend them to 32 bits
  always_comb begin
    data = acc;
    case (width)
      BYTE:    data = {{24{acc[7]}}, acc[7:0]};
      BYTE_U:  data = {24'h000000, acc[7:0]};
      HALF:    data = {{16{acc[15]}}, acc[15:0]};
      HALF_U:  data = {16'h0000, acc[15:0]};
      default: data = acc;
    endcase
  end

endmodule

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store unit: moves 1/2/4 bytes over an 8-bit RAM port.
module lsu_byte_serial
  import lsu_pkg::*;
#(
  parameter int CHECK_ALIGN = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_width,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              mem_own,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  LsuState           state;
  logic [1:0]        cnt;
  logic [1:0]        last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       acc;
  MemWidth           width_q;
  logic              write_q;
  logic              err_q;

  MemWidth           req_w;
  logic [2:0]        req_n;
  logic [1:0]        req_last;
  logic              req_misaligned;
  logic              req_ok;
  logic [1:0]        next_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        next_wbyte;
  logic [31:0]       ext_data;

  assign req_w      = MemWidth'(req_width);
  assign req_last   = req_n[1:0] - 2'd1;
  assign next_cnt   = cnt + 2'd1;
  assign next_addr  = addr_q + {{(ADDR_W-2){1'b0}}, next_cnt};
  assign next_wbyte = wdata_q[{next_cnt, 3'b000} +: 8];

  // Classify the incoming request: byte count, alignment and overall legality
  always_comb begin
    req_n          = width_bytes(req_w);
    req_misaligned = 1'b0;
    if (CHECK_ALIGN != 0) begin
      if (req_n == 3'd2) begin
        req_misaligned = req_addr[0];
      end else if (req_n == 3'd4) begin
        req_misaligned = |req_addr[1:0];
      end
    end
    req_ok = width_legal(req_w, req_write) && !req_misaligned;
  end

  lsu_load_extend u_extend (
    .acc   (acc),
    .width (width_q),
    .data  (ext_data)
  );

  // Load data is only presented alongside a successful load response
  assign resp_rdata = (resp_valid && !resp_error && !write_q) ? ext_data : 32'h0;

  // Sequencer: accept, walk the bytes on the RAM port, then pulse the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      last_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      acc        <= 32'h0;
      width_q    <= WORD;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      mem_own    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            width_q   <= req_w;
            write_q   <= req_write;
            last_q    <= req_last;
            acc       <= 32'h0;
            cnt       <= 2'd0;
            if (!req_ok) begin
              err_q      <= 1'b1;
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else begin
              err_q     <= 1'b0;
              state     <= XFER;
              mem_own   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= req_addr;
              mem_wdata <= req_write ? req_wdata[7:0] : 8'h00;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        XFER: begin
          if (!write_q) begin
            acc[{cnt, 3'b000} +: 8] <= mem_rdata;
          end
          cnt <= next_cnt;
          if (cnt == last_q) begin
            state      <= DONE;
            mem_own    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            resp_valid <= 1'b1;
            resp_error <= err_q;
          end else begin
            mem_addr  <= next_addr;
            mem_wdata <= write_q ? next_wbyte : 8'h00;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_serial.sv
// Directed bench for lsu_byte_serial: one instance checks alignment, one does not.
module tb_lsu_byte_serial;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        a_valid, a_ready, a_rv, a_err, a_own, a_we;
  logic [31:0] a_rdata, a_addr;
  logic [7:0]  a_wdata;
  logic        u_valid, u_ready, u_rv, u_err, u_own, u_we;
  logic [31:0] u_rdata, u_addr;
  logic [7:0]  u_wdata;

  logic        ready, rv, err, own, we;
  logic [31:0] rdata, maddr;
  logic [7:0]  mwdata;

  logic [7:0]  ram [0:4095];
  logic [31:0] bus_addr;
  logic [7:0]  bus_rdata;
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;

  int          checks;
  int          errors;
  int          n_xfer;
  int          n_we;
  int          resp_cycle;
  logic [31:0] got_rdata;
  logic        got_err;
  logic        rdy_at_resp;
  logic [31:0] addr_log [8];

  assign a_valid = req_valid && !sel;
  assign u_valid = req_valid && sel;

  assign ready  = sel ? u_ready : a_ready;
  assign rv     = sel ? u_rv    : a_rv;
  assign err    = sel ? u_err   : a_err;
  assign own    = sel ? u_own   : a_own;
  assign we     = sel ? u_we    : a_we;
  assign rdata  = sel ? u_rdata : a_rdata;
  assign maddr  = sel ? u_addr  : a_addr;
  assign mwdata = sel ? u_wdata : a_wdata;

  assign bus_addr  = a_own ? a_addr : u_addr;
  assign bus_rdata = ram[bus_addr[11:0]];

  lsu_byte_serial #(.CHECK_ALIGN(1), .ADDR_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(req_write),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_error(a_err),
    .mem_own(a_own), .mem_addr(a_addr), .mem_we(a_we),
    .mem_wdata(a_wdata), .mem_rdata(bus_rdata)
  );

  lsu_byte_serial #(.CHECK_ALIGN(0), .ADDR_W(32)) dut_u (
    .clk(clk), .rst_n(rst_n),
    .req_valid(u_valid), .req_ready(u_ready), .req_write(req_write),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(u_rv), .resp_rdata(u_rdata), .resp_error(u_err),
    .mem_own(u_own), .mem_addr(u_addr), .mem_we(u_we),
    .mem_wdata(u_wdata), .mem_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM: writes from either unit, plus a preload port for the bench
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (a_we) ram[a_addr[11:0]] <= a_wdata;
    if (u_we) ram[u_addr[11:0]] <= u_wdata;
  end

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issue one request on the selected unit and record what happens until the response
  task automatic run_req(input logic wr, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] d);
    int k;
    n_xfer = 0; n_we = 0; resp_cycle = -1;
    got_rdata = 'x; got_err = 1'bx; rdy_at_resp = 1'bx;
    @(negedge clk);
    req_write = wr; req_width = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    k = 0;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_width = 3'b111; req_write = ~wr;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (own) begin
        if (n_xfer < 8) addr_log[n_xfer] = maddr;
        n_xfer++;
      end
      if (we) n_we++;
      if (rv) begin
        resp_cycle = c; got_rdata = rdata; got_err = err; rdy_at_resp = ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (rv !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp: got valid %b error %b expected 0 0", rv, err); end
    checks++; if (own !== 1'b0 || we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_ctl: got own %b we %b expected 0 0", own, we); end
    checks++; if (maddr !== 32'h0 || mwdata !== 8'h0 || rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got addr %h wdata %h rdata %h expected zeros", maddr, mwdata, rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset: got %b expected 1", ready); end
  endtask

  task automatic test_load_word();
    sel = 1'b0;
    poke(12'h080, 8'h58); poke(12'h081, 8'h00); poke(12'h082, 8'h00); poke(12'h083, 8'h00);
    run_req(1'b0, 3'b010, 32'h80, 32'h0);
    checks++; if (resp_cycle !== 5) begin errors++; $display("[TB] FAIL lw_latency: got %0d expected 5", resp_cycle); end
    checks++; if (n_xfer !== 4 || n_we !== 0) begin errors++; $display("[TB] FAIL lw_xfer: got %0d xfer %0d we expected 4 0", n_xfer, n_we); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (addr_log[i] !== 32'h80 + i) begin errors++; $display("[TB] FAIL lw_addr%0d: got %h expected %h", i, addr_log[i], 32'h80 + i); end
    end
    checks++; if (got_rdata !== 32'h00000058 || got_err !== 1'b0) begin errors++; $display("[TB] FAIL lw_data: got %h err %b expected 00000058 0", got_rdata, got_err); end
    checks++; if (rdy_at_resp !== 1'b0) begin errors++; $display("[TB] FAIL ready_in_done: got %b expected 0", rdy_at_resp); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  w   [4];
    logic [31:0] exp [4];
    int          lat [4];
    w[0] = 3'b000; exp[0] = 32'hFFFFFFF0; lat[0] = 2;
    w[1] = 3'b100; exp[1] = 32'h000000F0; lat[1] = 2;
    w[2] = 3'b001; exp[2] = 32'hFFFF80F0; lat[2] = 3;
    w[3] = 3'b101; exp[3] = 32'h000080F0; lat[3] = 3;
    sel = 1'b0;
    poke(12'h090, 8'hF0); poke(12'h091, 8'h80);
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, w[i], 32'h90, 32'h0);
      checks++; if (got_rdata !== exp[i] || got_err !== 1'b0) begin errors++; $display("[TB] FAIL ext_w%b: got %h err %b expected %h 0", w[i], got_rdata, got_err, exp[i]); end
      checks++; if (resp_cycle !== lat[i]) begin errors++; $display("[TB] FAIL ext_lat_w%b: got %0d expected %0d", w[i], resp_cycle, lat[i]); end
    end
  endtask

  task automatic test_store_readback();
    sel = 1'b1;
    poke(12'h078, 8'h11); poke(12'h079, 8'h22); poke(12'h07A, 8'h33); poke(12'h07B, 8'h44);
    run_req(1'b1, 3'b001, 32'h79, 32'hDEADBEEF);
    checks++; if (n_we !== 2 || resp_cycle !== 3) begin errors++; $display("[TB] FAIL sh_cycles: got %0d we, resp at %0d expected 2, 3", n_we, resp_cycle); end
    checks++; if (got_rdata !== 32'h0 || got_err !== 1'b0) begin errors++; $display("[TB] FAIL sh_resp: got %h err %b expected 00000000 0", got_rdata, got_err); end
    checks++; if (ram[12'h079] !== 8'hEF || ram[12'h07A] !== 8'hBE || ram[12'h07B] !== 8'h44) begin errors++; $display("[TB] FAIL sh_ram: got %h %h %h expected ef be 44", ram[12'h079], ram[12'h07A], ram[12'h07B]); end
    run_req(1'b0, 3'b010, 32'h78, 32'h0);
    checks++; if (got_rdata !== 32'h44BEEF11) begin errors++; $display("[TB] FAIL sh_readback: got %h expected 44beef11", got_rdata); end
    poke(12'h102, 8'h01); poke(12'h103, 8'h02); poke(12'h104, 8'h03); poke(12'h105, 8'h04);
    run_req(1'b0, 3'b010, 32'h102, 32'h0);
    checks++; if (got_rdata !== 32'h04030201 || got_err !== 1'b0 || resp_cycle !== 5) begin errors++; $display("[TB] FAIL unaligned_lw: got %h err %b at %0d expected 04030201 0 at 5", got_rdata, got_err, resp_cycle); end
  endtask

  task automatic test_errors();
    logic        wr  [3];
    logic [2:0]  w   [3];
    logic [31:0] a   [3];
    wr[0] = 1'b0; w[0] = 3'b010; a[0] = 32'h102;
    wr[1] = 1'b0; w[1] = 3'b011; a[1] = 32'h100;
    wr[2] = 1'b1; w[2] = 3'b100; a[2] = 32'h100;
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_req(wr[i], w[i], a[i], 32'hCAFEF00D);
      checks++; if (resp_cycle !== 1 || got_err !== 1'b1) begin errors++; $display("[TB] FAIL err%0d_resp: got at %0d err %b expected at 1 err 1", i, resp_cycle, got_err); end
      checks++; if (got_rdata !== 32'h0 || n_xfer !== 0 || n_we !== 0) begin errors++; $display("[TB] FAIL err%0d_side: got rdata %h own %0d we %0d expected 0 0 0", i, got_rdata, n_xfer, n_we); end
    end
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    poke(12'hFFE, 8'hA1); poke(12'hFFF, 8'hB2); poke(12'h000, 8'hC3); poke(12'h001, 8'hD4);
    run_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    checks++; if (addr_log[0] !== 32'hFFFFFFFE || addr_log[1] !== 32'hFFFFFFFF || addr_log[2] !== 32'h0 || addr_log[3] !== 32'h1) begin errors++; $display("[TB] FAIL wrap_addr: got %h %h %h %h expected fffffffe ffffffff 00000000 00000001", addr_log[0], addr_log[1], addr_log[2], addr_log[3]); end
    checks++; if (got_rdata !== 32'hD4C3B2A1 || n_xfer !== 4) begin errors++; $display("[TB] FAIL wrap_data: got %h in %0d xfers expected d4c3b2a1 in 4", got_rdata, n_xfer); end
  endtask

  task automatic test_reset_mid_store();
    int k;
    int seen_rv;
    sel = 1'b0;
    poke(12'h200, 8'h00); poke(12'h201, 8'h00); poke(12'h202, 8'h00);
    @(negedge clk);
    req_write = 1'b1; req_width = 3'b010; req_addr = 32'h200; req_wdata = 32'h12345678; req_valid = 1'b1;
    k = 0;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (we !== 1'b0 || ready !== 1'b0 || own !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ctl: got we %b ready %b own %b expected 0 0 0", we, ready, own); end
    seen_rv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rv) seen_rv++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rv) seen_rv++;
    end
    checks++; if (seen_rv !== 0) begin errors++; $display("[TB] FAIL midrst_no_resp: got %0d responses expected 0", seen_rv); end
    checks++; if (ram[12'h200] !== 8'h78 || ram[12'h201] !== 8'h00 || ram[12'h202] !== 8'h00) begin errors++; $display("[TB] FAIL midrst_ram: got %h %h %h expected 78 00 00", ram[12'h200], ram[12'h201], ram[12'h202]); end
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 1", ready); end
    run_req(1'b0, 3'b000, 32'h90, 32'h0);
    checks++; if (got_rdata !== 32'hFFFFFFF0 || resp_cycle !== 2 || got_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_lb: got %h at %0d err %b expected fffffff0 at 2 err 0", got_rdata, resp_cycle, got_err); end
  endtask

  initial begin
    checks = 0; errors = 0;
    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_width = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    pl_en = 1'b0; pl_addr = 12'h0; pl_data = 8'h0;
    test_reset();
    test_load_word();
    test_load_extend();
    test_store_readback();
    test_errors();
    test_wrap();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
